// File: rtl/id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : id_queue
//  Description : Instruction-decode stage fronted by a small FIFO of fetched
//                {pc, inst} pairs. The queue head is decoded combinationally,
//                checked for RAW hazards against EX/MEM/ID destinations, and
//                issued into a registered output stage with valid/ready flow.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    if_valid_i,
  output logic                    if_ready_o,
  input  logic [31:0]             if_pc_i,
  input  logic [31:0]             if_inst_i,
  output logic                    reg1_read_o,
  output logic                    reg2_read_o,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [31:0]             reg1_data_i,
  input  logic [31:0]             reg2_data_i,
  input  logic                    ex_wreg_i,
  input  logic [4:0]              ex_wd_i,
  input  logic                    mem_wreg_i,
  input  logic [4:0]              mem_wd_i,
  input  logic                    ex_ready_i,
  output logic                    id_valid_o,
  output logic [31:0]             pc_o,
  output logic [7:0]              aluop_o,
  output logic [2:0]              alusel_o,
  output logic [31:0]             reg1_o,
  output logic [31:0]             reg2_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic                    instvalid_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  // ALU operation encodings
  localparam logic [7:0] c_ALU_NOP   = 8'h00;
  localparam logic [7:0] c_ALU_AND   = 8'h24;
  localparam logic [7:0] c_ALU_OR    = 8'h25;
  localparam logic [7:0] c_ALU_XOR   = 8'h26;
  localparam logic [7:0] c_ALU_NOR   = 8'h27;
  localparam logic [7:0] c_ALU_SLT   = 8'h2A;
  localparam logic [7:0] c_ALU_SLTU  = 8'h2B;
  localparam logic [7:0] c_ALU_SLL   = 8'h7C;
  localparam logic [7:0] c_ALU_SRL   = 8'h02;
  localparam logic [7:0] c_ALU_SRA   = 8'h03;
  localparam logic [7:0] c_ALU_SLLV  = 8'h04;
  localparam logic [7:0] c_ALU_SRLV  = 8'h06;
  localparam logic [7:0] c_ALU_SRAV  = 8'h07;
  localparam logic [7:0] c_ALU_ADD   = 8'h20;
  localparam logic [7:0] c_ALU_ADDU  = 8'h21;
  localparam logic [7:0] c_ALU_SUB   = 8'h22;
  localparam logic [7:0] c_ALU_SUBU  = 8'h23;
  localparam logic [7:0] c_ALU_MOVZ  = 8'h0A;
  localparam logic [7:0] c_ALU_MOVN  = 8'h0B;
  localparam logic [7:0] c_ALU_MFHI  = 8'h10;
  localparam logic [7:0] c_ALU_MTHI  = 8'h11;
  localparam logic [7:0] c_ALU_MFLO  = 8'h12;
  localparam logic [7:0] c_ALU_MTLO  = 8'h13;
  localparam logic [7:0] c_ALU_MULT  = 8'h18;
  localparam logic [7:0] c_ALU_MULTU = 8'h19;
  localparam logic [7:0] c_ALU_DIV   = 8'h1A;
  localparam logic [7:0] c_ALU_DIVU  = 8'h1B;

  // Result-select encodings
  localparam logic [2:0] c_SEL_NOP   = 3'd0;
  localparam logic [2:0] c_SEL_LOGIC = 3'd1;
  localparam logic [2:0] c_SEL_SHIFT = 3'd2;
  localparam logic [2:0] c_SEL_MOVE  = 3'd3;
  localparam logic [2:0] c_SEL_ARITH = 3'd4;

  // Queue storage and bookkeeping
  logic [63:0]     mem_q [DEPTH];
  logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0] count_q, count_d;

  // Output stage
  logic        valid_q;
  logic [31:0] pc_q, reg1_q, reg2_q;
  logic [7:0]  aluop_q;
  logic [2:0]  alusel_q;
  logic [4:0]  wd_q;
  logic        wreg_q, instvalid_q;

  // Head fields
  logic [63:0] w_head;
  logic [31:0] w_inst;
  logic [5:0]  w_f_op, w_f_fn;
  logic [4:0]  w_f_rs, w_f_rt, w_f_rd, w_f_sa;
  logic [15:0] w_f_imm;

  // Decode results
  logic        w_re1, w_re2, w_is_i, w_movz, w_movn, w_wreg, w_ivalid;
  logic [4:0]  w_a1, w_a2, w_wd;
  logic [31:0] w_imm, w_opnd1, w_opnd2;
  logic [7:0]  w_aluop;
  logic [2:0]  w_alusel;
  logic        w_wreg_fin;

  // Flow control
  logic w_present, w_re1_eff, w_re2_eff, w_haz1, w_haz2, w_issue, w_push, w_pop;

  assign w_head  = mem_q[rd_ptr_q];
  assign w_inst  = w_head[31:0];
  assign w_f_op  = w_inst[31:26];
  assign w_f_rs  = w_inst[25:21];
  assign w_f_rt  = w_inst[20:16];
  assign w_f_rd  = w_inst[15:11];
  assign w_f_sa  = w_inst[10:6];
  assign w_f_fn  = w_inst[5:0];
  assign w_f_imm = w_inst[15:0];

  // Combinational decode of the queue head
  always_comb begin
    w_re1    = 1'b0;
    w_re2    = 1'b0;
    w_a1     = w_f_rs;
    w_a2     = w_f_rt;
    w_imm    = 32'h0;
    w_aluop  = c_ALU_NOP;
    w_alusel = c_SEL_NOP;
    w_wd     = 5'd0;
    w_wreg   = 1'b0;
    w_ivalid = 1'b0;
    w_movz   = 1'b0;
    w_movn   = 1'b0;
    w_is_i   = 1'b0;
    case (w_f_op)
      6'h00: begin
        w_re1    = 1'b1;
        w_re2    = 1'b1;
        w_wd     = w_f_rd;
        w_wreg   = 1'b1;
        w_ivalid = 1'b1;
        case (w_f_fn)
          6'h24: begin w_aluop = c_ALU_AND;  w_alusel = c_SEL_LOGIC; end
          6'h25: begin w_aluop = c_ALU_OR;   w_alusel = c_SEL_LOGIC; end
          6'h26: begin w_aluop = c_ALU_XOR;  w_alusel = c_SEL_LOGIC; end
          6'h27: begin w_aluop = c_ALU_NOR;  w_alusel = c_SEL_LOGIC; end
          6'h2A: begin w_aluop = c_ALU_SLT;  w_alusel = c_SEL_ARITH; end
          6'h2B: begin w_aluop = c_ALU_SLTU; w_alusel = c_SEL_ARITH; end
          6'h20: begin w_aluop = c_ALU_ADD;  w_alusel = c_SEL_ARITH; end
          6'h21: begin w_aluop = c_ALU_ADDU; w_alusel = c_SEL_ARITH; end
          6'h22: begin w_aluop = c_ALU_SUB;  w_alusel = c_SEL_ARITH; end
          6'h23: begin w_aluop = c_ALU_SUBU; w_alusel = c_SEL_ARITH; end
          6'h04: begin w_aluop = c_ALU_SLLV; w_alusel = c_SEL_SHIFT; end
          6'h06: begin w_aluop = c_ALU_SRLV; w_alusel = c_SEL_SHIFT; end
          6'h07: begin w_aluop = c_ALU_SRAV; w_alusel = c_SEL_SHIFT; end
          // Immediate shifts take the shift amount through operand 1
          6'h00: begin w_aluop = c_ALU_SLL; w_alusel = c_SEL_SHIFT; w_re1 = 1'b0; w_imm = {27'h0, w_f_sa}; end
          6'h02: begin w_aluop = c_ALU_SRL; w_alusel = c_SEL_SHIFT; w_re1 = 1'b0; w_imm = {27'h0, w_f_sa}; end
          6'h03: begin w_aluop = c_ALU_SRA; w_alusel = c_SEL_SHIFT; w_re1 = 1'b0; w_imm = {27'h0, w_f_sa}; end
          6'h0A: begin w_aluop = c_ALU_MOVZ; w_alusel = c_SEL_MOVE; w_movz = 1'b1; end
          6'h0B: begin w_aluop = c_ALU_MOVN; w_alusel = c_SEL_MOVE; w_movn = 1'b1; end
          6'h10: begin w_aluop = c_ALU_MFHI; w_alusel = c_SEL_MOVE; w_re1 = 1'b0; w_re2 = 1'b0; end
          6'h12: begin w_aluop = c_ALU_MFLO; w_alusel = c_SEL_MOVE; w_re1 = 1'b0; w_re2 = 1'b0; end
          // HI/LO writers produce no GPR result
          6'h11: begin w_aluop = c_ALU_MTHI;  w_re2 = 1'b0; w_wreg = 1'b0; end
          6'h13: begin w_aluop = c_ALU_MTLO;  w_re2 = 1'b0; w_wreg = 1'b0; end
          6'h18: begin w_aluop = c_ALU_MULT;  w_wreg = 1'b0; end
          6'h19: begin w_aluop = c_ALU_MULTU; w_wreg = 1'b0; end
          6'h1A: begin w_aluop = c_ALU_DIV;   w_wreg = 1'b0; end
          6'h1B: begin w_aluop = c_ALU_DIVU;  w_wreg = 1'b0; end
          default: begin
            w_re1    = 1'b0;
            w_re2    = 1'b0;
            w_wd     = 5'd0;
            w_wreg   = 1'b0;
            w_ivalid = 1'b0;
          end
        endcase
      end
      6'h0C: begin w_is_i = 1'b1; w_aluop = c_ALU_AND;  w_alusel = c_SEL_LOGIC; w_imm = {16'h0, w_f_imm}; end
      6'h0D: begin w_is_i = 1'b1; w_aluop = c_ALU_OR;   w_alusel = c_SEL_LOGIC; w_imm = {16'h0, w_f_imm}; end
      6'h0E: begin w_is_i = 1'b1; w_aluop = c_ALU_XOR;  w_alusel = c_SEL_LOGIC; w_imm = {16'h0, w_f_imm}; end
      // LUI is an OR of $0 with the upper-placed immediate
      6'h0F: begin w_is_i = 1'b1; w_aluop = c_ALU_OR;   w_alusel = c_SEL_LOGIC; w_imm = {w_f_imm, 16'h0}; end
      6'h0A: begin w_is_i = 1'b1; w_aluop = c_ALU_SLT;  w_alusel = c_SEL_ARITH; w_imm = {{16{w_f_imm[15]}}, w_f_imm}; end
      6'h0B: begin w_is_i = 1'b1; w_aluop = c_ALU_SLTU; w_alusel = c_SEL_ARITH; w_imm = {{16{w_f_imm[15]}}, w_f_imm}; end
      6'h08: begin w_is_i = 1'b1; w_aluop = c_ALU_ADD;  w_alusel = c_SEL_ARITH; w_imm = {{16{w_f_imm[15]}}, w_f_imm}; end
      6'h09: begin w_is_i = 1'b1; w_aluop = c_ALU_ADDU; w_alusel = c_SEL_ARITH; w_imm = {{16{w_f_imm[15]}}, w_f_imm}; end
      default: begin
        w_is_i = 1'b0;
      end
    endcase
    if (w_is_i) begin
      w_re1    = 1'b1;
      w_wd     = w_f_rt;
      w_wreg   = 1'b1;
      w_ivalid = 1'b1;
      if (w_f_op == 6'h0F) begin
        w_a1 = 5'd0;
      end
    end
  end

  assign w_present   = (count_q != '0);
  assign w_re1_eff   = w_present & w_re1;
  assign w_re2_eff   = w_present & w_re2;
  assign reg1_read_o = w_re1_eff;
  assign reg2_read_o = w_re2_eff;
  assign reg1_addr_o = w_a1;
  assign reg2_addr_o = w_a2;

  assign w_opnd1 = w_re1_eff ? reg1_data_i : w_imm;
  assign w_opnd2 = w_re2_eff ? reg2_data_i : w_imm;

  // Conditional moves only write when the test operand meets the condition
  assign w_wreg_fin = w_movz ? (w_opnd2 == 32'h0) :
                      w_movn ? (w_opnd2 != 32'h0) : w_wreg;

  // A source register is blocked while any older in-flight instruction targets it
  assign w_haz1 = w_re1_eff && (w_a1 != 5'd0) &&
                  ((ex_wreg_i && (ex_wd_i == w_a1)) ||
                   (mem_wreg_i && (mem_wd_i == w_a1)) ||
                   (valid_q && wreg_q && (wd_q == w_a1)));
  assign w_haz2 = w_re2_eff && (w_a2 != 5'd0) &&
                  ((ex_wreg_i && (ex_wd_i == w_a2)) ||
                   (mem_wreg_i && (mem_wd_i == w_a2)) ||
                   (valid_q && wreg_q && (wd_q == w_a2)));

  assign w_issue    = w_present && !w_haz1 && !w_haz2 && (!valid_q || ex_ready_i);
  assign if_ready_o = (count_q < c_CW'(DEPTH));
  assign w_push     = if_valid_i && if_ready_o && !flush_i;
  assign w_pop      = w_issue && !flush_i;

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + c_CW'(w_push) - c_CW'(w_pop);
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_AW'(1);
    end
  end

  // Pointer and occupancy registers; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      mem_q[wr_ptr_q] <= {if_pc_i, if_inst_i};
    end
  end

  // Output stage: load on issue, drop valid on drain, hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'h0;
      aluop_q     <= c_ALU_NOP;
      alusel_q    <= c_SEL_NOP;
      reg1_q      <= 32'h0;
      reg2_q      <= 32'h0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
      instvalid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (w_issue) begin
      valid_q     <= 1'b1;
      pc_q        <= w_head[63:32];
      aluop_q     <= w_aluop;
      alusel_q    <= w_alusel;
      reg1_q      <= w_opnd1;
      reg2_q      <= w_opnd2;
      wd_q        <= w_wd;
      wreg_q      <= w_wreg_fin;
      instvalid_q <= w_ivalid;
    end else if (valid_q && ex_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign id_valid_o  = valid_q;
  assign pc_o        = pc_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign instvalid_o = instvalid_q;
  assign count_o     = count_q;

endmodule
`default_nettype wire

// File: doc/id_queue.md
ID_QUEUE -- requirements
Module: id_queue

Interface
REQ-001 Parameter: DEPTH, default 4, instruction-queue entries; power of two, minimum 2.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 flush_i  in  1  discard queue and output stage.
REQ-006 if_valid_i  in  1  fetch presents an instruction.
REQ-007 if_ready_o  out  1  queue can accept; high iff count_o < DEPTH.
REQ-008 if_pc_i  in  32  PC of the presented instruction.
REQ-009 if_inst_i  in  32  presented instruction word.
REQ-010 reg1_read_o / reg2_read_o  out  1 each  regfile read enables for the queue head.
REQ-011 reg1_addr_o / reg2_addr_o  out  5 each  regfile read addresses for the queue head.
REQ-012 reg1_data_i / reg2_data_i  in  32 each  regfile read data, same cycle.
REQ-013 ex_wreg_i, ex_wd_i  in  1, 5  EX-stage write enable and destination.
REQ-014 mem_wreg_i, mem_wd_i  in  1, 5  MEM-stage write enable and destination.
REQ-015 ex_ready_i  in  1  EX accepts the current output this cycle.
REQ-016 id_valid_o  out  1  output stage holds a decoded instruction.
REQ-017 pc_o, aluop_o, alusel_o  out  32, 8, 3  decoded PC, ALU op, result select (project encodings).
REQ-018 reg1_o, reg2_o  out  32 each  source operands.
REQ-019 wd_o, wreg_o, instvalid_o  out  5, 1, 1  destination, write enable, legal-encoding flag.
REQ-020 count_o  out  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-021 Push: if_valid_i && if_ready_o && !flush_i writes {pc, inst} at tail; if_ready_o does not depend on same-cycle pop.
REQ-022 Head decode: combinational; read enables/addresses from head; when queue empty both enables 0.
REQ-023 Decode set: SPECIAL AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV ADD ADDU SUB SUBU MOVZ MOVN MFHI MTHI MFLO MTLO MULT MULTU DIV DIVU; I-type ANDI ORI XORI LUI SLTI SLTIU ADDI ADDIU.
REQ-024 Immediates: logic ops zero-extend; SLTI/SLTIU/ADDI/ADDIU sign-extend; LUI = {imm16,16'h0}, aluop OR, reg1 address forced 0; shifts use {27'h0, sa}.
REQ-025 Operand: readN_o ? regN_data_i : 32-bit immediate, independently per port.
REQ-026 Unknown encoding: instvalid_o=0, wreg_o=0, aluop/alusel NOP, still issued.
REQ-027 Hazard: head read port N enabled, address nonzero, and equal to ex_wd_i (ex_wreg_i), mem_wd_i (mem_wreg_i), or wd_o (id_valid_o && wreg_o) -> head not issued.
REQ-028 Issue condition: head present && no hazard && (!id_valid_o || ex_ready_i); issue pops head and registers all decode outputs, id_valid_o=1.
REQ-029 Stall: id_valid_o && !ex_ready_i -> every output holds its value.
REQ-030 Drain: id_valid_o && ex_ready_i && no issue -> id_valid_o=0 next edge.
REQ-031 Latency: instruction pushed at edge k into an empty, unstalled queue appears at edge k+1; no empty-queue bypass.
REQ-032 Full: count_o=DEPTH -> if_ready_o=0; same-cycle pop and push never coexist at full.
REQ-033 Pointers wrap modulo DEPTH; count_o = pushes minus pops, never exceeding DEPTH.
REQ-034 Flush: occupancy 0, pointers 0, id_valid_o=0 next edge; overrides push, issue and stall in that cycle.

Reset
REQ-035 rst high at an edge: pointers and count_o 0, id_valid_o 0, pc_o/reg1_o/reg2_o 0, aluop_o/alusel_o NOP, wd_o 0, wreg_o 0, instvalid_o 0; rst overrides flush_i and push.
REQ-036 Reset asserted mid-stall or mid-push discards all queued entries; if_ready_o=1 the cycle after release.

Verification
REQ-037 ORI $2,$1,0x8000, regfile $1=0x0000_00FF, ex_ready_i=1 -> aluop OR, reg1_o=0xFF, reg2_o=0x0000_8000, wd_o=2, wreg_o=1.
REQ-038 ADDIU $3,$0,0xFFFF -> reg2_o=0xFFFF_FFFF, aluop ADDU; SLL $4,$5,31 -> reg1_o=0x0000_001F, reg1_read_o=0.
REQ-039 Push DEPTH+2 beats with ex_ready_i=0 -> one issued, if_ready_o low at count_o=DEPTH, order preserved on release.
REQ-040 ADDU $6 issued, then AND $7,$6,$6 with ex_wreg_i=1, ex_wd_i=6 -> AND held until both wd matches clear; head with rs=$0 never held.
REQ-041 Flush with 3 queued and id_valid_o=1 plus concurrent push -> count_o=0, id_valid_o=0, pushed beat dropped.
REQ-042 Opcode 0x3F -> instvalid_o=0, wreg_o=0, aluop NOP, id_valid_o=1 for one transfer.
